multicycle_control: RTL and testbench

- Multi-cycle control FSM for the 16-bit, 4-register MIPS-subset ISA (4-bit opcode in IR[15:12]).
- Replaces single-cycle MainControl once instruction and data memory share one port with variable latency.
- Sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Drives the multi-cycle datapath's register enables, mux selects and ALU control, and waits on a memory-ready handshake.

---
 rtl/multicycle_control.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle control FSM for the 16-bit, 4-register MIPS-subset ISA.
//   Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK over 3-5 cycles
//   per instruction against a single shared, variable-latency memory port.
//
//   Optional feature: define MCTL_HALT_EN to make opcode 1111 enter a
//   sticky HALT state (left only by reset). Without it, 1111 is illegal.
//
// Parameters
//   WAIT_LIMIT : max wait cycles in FETCH/MEMRD/MEMWR before abort (1..255)
//   CNT_W      : wait counter width, must hold WAIT_LIMIT
//
// Ports
//   clock      in   system clock, state updates on the falling edge
//   reset      in   synchronous active-high reset
//   op[3:0]    in   opcode from latched IR[15:12]
//   zero       in   ALU zero flag
//   mem_ready  in   memory access completes this cycle
//   pc_write   out  PC enable        ir_write   out  IR latch enable
//   i_or_d     out  addr sel 0=PC/1=ALUOut
//   mem_read   out  memory read      mem_write  out  memory write strobe
//   reg_write  out  RF write enable  reg_dst    out  0=IR[9:8], 1=IR[7:6]
//   mem_to_reg out  0=ALUOut, 1=MDR alu_src_a  out  0=PC, 1=A
//   alu_src_b  out  00=B 01=2 10=imm 11=imm<<1
//   alu_ctl    out  ALU op code
//   pc_source  out  0=ALU result, 1=ALUOut
//   illegal_op out  pulse on unsupported opcode
//   mem_err    out  pulse on memory timeout abort
//   halted     out  high in HALT
//   state[3:0] out  current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctl,
  output logic       pc_source,
  output logic       illegal_op,
  output logic       mem_err,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wait_state;
  logic             timeout;

  assign state = cur;

  // Next-state and wait-counter logic
  always_comb begin
    wait_state = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    timeout    = wait_state && !mem_ready && (wait_cnt == LIMIT);
    nxt        = cur;
    case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        if (op <= 4'b0110)                      nxt = S_REXE;
        else if (op == 4'b0111)                 nxt = S_IEXE;
        else if (op == 4'b1000 || op == 4'b1001) nxt = S_MEMADR;
        else if (op == 4'b1010 || op == 4'b1011) nxt = S_BRANCH;
`ifdef MCTL_HALT_EN
        else if (op == 4'b1111)                 nxt = S_HALT;
`endif
        else                                    nxt = S_FETCH;
      end
      S_MEMADR: nxt = (op == 4'b1001) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_REXE:   nxt = S_RWB;
      S_IEXE:   nxt = S_IWB;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
    // A timeout abandons the access; a fetch timeout retries the same PC.
    if (timeout) nxt = S_FETCH;

    // Any state change (or a timeout re-entry into FETCH) restarts the count.
    if ((nxt != cur) || timeout)
      cnt_next = '0;
    else if (wait_state && !mem_ready)
      cnt_next = wait_cnt + CNT_W'(1);
    else
      cnt_next = wait_cnt;
  end

  // State register (falling edge)
  always_ff @(negedge clock) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= cnt_next;
    end
  end

  // Moore output decode with mem_ready / zero / reset gating
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = 4'b0000;
    pc_source  = 1'b0;
    illegal_op = 1'b0;
    mem_err    = timeout;
    halted     = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctl   = ALU_ADD;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctl   = ALU_ADD;
`ifdef MCTL_HALT_EN
        illegal_op = (op >= 4'b1100) && (op != 4'b1111);
`else
        illegal_op = (op >= 4'b1100);
`endif
      end
      S_MEMADR, S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctl   = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = !timeout;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        case (op)
          4'b0000: alu_ctl = ALU_ADD;
          4'b0001: alu_ctl = ALU_SUB;
          4'b0010: alu_ctl = ALU_AND;
          4'b0011: alu_ctl = ALU_OR;
          4'b0100: alu_ctl = ALU_NOR;
          4'b0101: alu_ctl = ALU_NAND;
          4'b0110: alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_source = 1'b1;
        pc_write  = ((op == 4'b1010) && zero) || ((op == 4'b1011) && !zero);
      end
`ifdef MCTL_HALT_EN
      S_HALT: halted = 1'b1;
`endif
      default: ;
    endcase
    // Reset suppresses every side effect in the cycle it is applied.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, pc_source;
  logic       illegal_op, mem_err, halted;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctl, state;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.WAIT_LIMIT(3), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .pc_source(pc_source),
    .illegal_op(illegal_op), .mem_err(mem_err), .halted(halted), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the rising edge; state moves on the falling edge, so
  // outputs sampled 1 ns later reflect the current state and new inputs.
  task automatic cyc(input logic r, input logic [3:0] o, input logic z, input logic mr);
    @(posedge clock);
    reset = r; op = o; zero = z; mem_ready = mr;
    #1;
  endtask

  task automatic fetch_ok(input logic [3:0] o);
    cyc(1'b0, o, 1'b0, 1'b1);
    chk("fetch_state", state, 8'd0);
    chk("fetch_pcw", pc_write, 8'd1);
    chk("fetch_irw", ir_write, 8'd1);
  endtask

  task automatic branch_case(input logic [3:0] o, input logic z, input logic exp_pcw);
    fetch_ok(o);
    cyc(1'b0, o, z, 1'b0);
    chk("br_dec_state", state, 8'd1);
    cyc(1'b0, o, z, 1'b0);
    chk("br_state", state, 8'd8);
    chk("br_pcw", pc_write, {7'd0, exp_pcw});
    chk("br_pcsrc", pc_source, 8'd1);
    chk("br_aluctl", alu_ctl, 8'b0110);
  endtask

  task automatic rexe_case(input logic [3:0] o, input logic [3:0] exp_ctl);
    fetch_ok(o);
    cyc(1'b0, o, 1'b0, 1'b1);
    cyc(1'b0, o, 1'b0, 1'b1);
    chk("rexe_state", state, 8'd6);
    chk("rexe_aluctl", alu_ctl, {4'd0, exp_ctl});
    cyc(1'b0, o, 1'b0, 1'b1);
    chk("rwb_state", state, 8'd7);
  endtask

  initial begin
    // Reset held two cycles with mem_ready=1: no enables may fire.
    cyc(1'b1, 4'd0, 1'b0, 1'b1);
    chk("rst_pcw", pc_write, 8'd0);
    chk("rst_irw", ir_write, 8'd0);
    chk("rst_regw", reg_write, 8'd0);
    chk("rst_memw", mem_write, 8'd0);
    cyc(1'b1, 4'd0, 1'b0, 1'b1);
    chk("rst_state", state, 8'd0);
    chk("rst_pcw2", pc_write, 8'd0);
    chk("rst_err", {illegal_op, mem_err, halted}, 8'd0);

    // R-type add: 0,1,6,7,0
    fetch_ok(4'b0000);
    chk("fetch_memrd", mem_read, 8'd1);
    chk("fetch_srcb", alu_src_b, 8'b01);
    chk("fetch_aluctl", alu_ctl, 8'b0010);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("dec_state", state, 8'd1);
    chk("dec_pcw", pc_write, 8'd0);
    chk("dec_irw", ir_write, 8'd0);
    chk("dec_srcb", alu_src_b, 8'b11);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("rexe_state", state, 8'd6);
    chk("rexe_aluctl", alu_ctl, 8'b0010);
    chk("rexe_srca", alu_src_a, 8'd1);
    chk("rexe_srcb", alu_src_b, 8'b00);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("rwb_state", state, 8'd7);
    chk("rwb_regw", reg_write, 8'd1);
    chk("rwb_regdst", reg_dst, 8'd1);
    chk("rwb_memtoreg", mem_to_reg, 8'd0);

    rexe_case(4'b0001, 4'b0110);
    rexe_case(4'b0100, 4'b1100);
    rexe_case(4'b0110, 4'b0111);

    // Immediate: IEXE then IWB
    fetch_ok(4'b0111);
    cyc(1'b0, 4'b0111, 1'b0, 1'b1);
    cyc(1'b0, 4'b0111, 1'b0, 1'b1);
    chk("iexe_state", state, 8'd9);
    chk("iexe_srcb", alu_src_b, 8'b10);
    cyc(1'b0, 4'b0111, 1'b0, 1'b1);
    chk("iwb_state", state, 8'd10);
    chk("iwb_regw", reg_write, 8'd1);
    chk("iwb_regdst", reg_dst, 8'd0);

    // Load with mem_ready low 3 cycles: ready arrives in the limit cycle.
    fetch_ok(4'b1000);
    cyc(1'b0, 4'b1000, 1'b0, 1'b1);
    cyc(1'b0, 4'b1000, 1'b0, 1'b1);
    chk("memadr_state", state, 8'd2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b1000, 1'b0, 1'b0);
      chk("memrd_wait_state", state, 8'd3);
      chk("memrd_iord", i_or_d, 8'd1);
      chk("memrd_err", mem_err, 8'd0);
    end
    cyc(1'b0, 4'b1000, 1'b0, 1'b1);
    chk("memrd_last_state", state, 8'd3);
    chk("memrd_limit_noerr", mem_err, 8'd0);
    cyc(1'b0, 4'b1000, 1'b0, 1'b0);
    chk("memwb_state", state, 8'd4);
    chk("memwb_regw", reg_write, 8'd1);
    chk("memwb_m2r", mem_to_reg, 8'd1);

    // Store completing after one wait cycle
    fetch_ok(4'b1001);
    cyc(1'b0, 4'b1001, 1'b0, 1'b1);
    cyc(1'b0, 4'b1001, 1'b0, 1'b1);
    cyc(1'b0, 4'b1001, 1'b0, 1'b0);
    chk("memwr_state", state, 8'd5);
    chk("memwr_we", mem_write, 8'd1);
    cyc(1'b0, 4'b1001, 1'b0, 1'b1);
    chk("memwr_we2", mem_write, 8'd1);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("memwr_done_state", state, 8'd0);

    // Store timeout: 4th cycle aborts with no write
    cyc(1'b0, 4'b1001, 1'b0, 1'b1);
    cyc(1'b0, 4'b1001, 1'b0, 1'b1);
    cyc(1'b0, 4'b1001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b1001, 1'b0, 1'b0);
      chk("memwr_to_state", state, 8'd5);
      chk("memwr_to_err", mem_err, 8'd0);
    end
    cyc(1'b0, 4'b1001, 1'b0, 1'b0);
    chk("memwr_to_err4", mem_err, 8'd1);
    chk("memwr_to_we", mem_write, 8'd0);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("memwr_to_next", state, 8'd0);
    chk("memwr_to_pulse", mem_err, 8'd0);

    // Fetch timeout: 3 more cycles low, 4th pulses mem_err
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 4'b0000, 1'b0, 1'b0);
      chk("fto_err", mem_err, 8'd0);
      chk("fto_wr", {pc_write, ir_write}, 8'd0);
    end
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("fto_err4", mem_err, 8'd1);
    chk("fto_wr4", {pc_write, ir_write}, 8'd0);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("fto_state", state, 8'd0);
    chk("fto_pulse", mem_err, 8'd0);
    // Retry succeeds with a fresh count
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("fto_retry_err", mem_err, 8'd0);
    cyc(1'b0, 4'b1011, 1'b0, 1'b1);
    chk("fto_retry_pcw", pc_write, 8'd1);
    cyc(1'b0, 4'b1011, 1'b0, 1'b0);
    cyc(1'b0, 4'b1011, 1'b0, 1'b0);
    chk("br_after_retry", pc_write, 8'd1);

    branch_case(4'b1011, 1'b1, 1'b0);
    branch_case(4'b1010, 1'b1, 1'b1);
    branch_case(4'b1010, 1'b0, 1'b0);

    // Illegal opcode
    fetch_ok(4'b1100);
    cyc(1'b0, 4'b1100, 1'b0, 1'b1);
    chk("ill_pulse", illegal_op, 8'd1);
    chk("ill_wr", {reg_write, mem_write}, 8'd0);
    cyc(1'b0, 4'b1100, 1'b0, 1'b0);
    chk("ill_next", state, 8'd0);
    chk("ill_once", illegal_op, 8'd0);

    // Reset applied mid-instruction (RWB): no write, back to FETCH
    fetch_ok(4'b0000);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1);
    cyc(1'b1, 4'b0000, 1'b0, 1'b1);
    chk("midrst_state", state, 8'd7);
    chk("midrst_regw", reg_write, 8'd0);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("midrst_next", state, 8'd0);

    // Opcode 1111
    fetch_ok(4'b1111);
    cyc(1'b0, 4'b1111, 1'b0, 1'b1);
`ifdef MCTL_HALT_EN
    chk("halt_noill", illegal_op, 8'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      chk("halt_state", state, 8'd11);
      chk("halt_flag", halted, 8'd1);
      chk("halt_en", {pc_write, ir_write, mem_write, reg_write}, 8'd0);
    end
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    chk("halt_rst_flag", halted, 8'd0);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("halt_rst_state", state, 8'd0);
    chk("halt_rst_flag2", halted, 8'd0);
`else
    chk("op15_ill", illegal_op, 8'd1);
    chk("op15_halted", halted, 8'd0);
    cyc(1'b0, 4'b1111, 1'b0, 1'b0);
    chk("op15_next", state, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
